// File: rtl/conv3x3_engine.sv
// conv3x3_engine: 3-stage pipelined 3x3 signed-kernel convolution with shift and clamp; define CONV3X3_ABS_EN to output the magnitude of negative sums
module conv3x3_engine #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              win_valid,
  input  logic [PIX_W-1:0]  p1,
  input  logic [PIX_W-1:0]  p2,
  input  logic [PIX_W-1:0]  p3,
  input  logic [PIX_W-1:0]  p4,
  input  logic [PIX_W-1:0]  p5,
  input  logic [PIX_W-1:0]  p6,
  input  logic [PIX_W-1:0]  p7,
  input  logic [PIX_W-1:0]  p8,
  input  logic [PIX_W-1:0]  p9,
  input  logic              coef_wr,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_valid,
  output logic [5:0]        out_row,
  output logic [5:0]        out_col,
  output logic              frame_done,
  output logic              busy,
  output logic              coef_err
);
  localparam int PROD_W = PIX_W + COEF_W + 1;
  localparam int ROW_W  = PROD_W + 2;
  localparam int SUM_W  = PROD_W + 4;
  logic [PIX_W-1:0] pix [9];
  logic signed [COEF_W-1:0] k_q [9];
  logic signed [COEF_W-1:0] k_d [9];
  logic [3:0] shift_q, shift_d;
  logic coef_err_q, coef_err_d;
  logic coef_hit, coef_drop;
  logic signed [PROD_W-1:0] prod_q [9];
  logic signed [PROD_W-1:0] prod_d [9];
  logic signed [ROW_W-1:0] row_sum_q [3];
  logic signed [ROW_W-1:0] row_sum_d [3];
  logic signed [SUM_W-1:0] sum, shifted, mag;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [5:0] row_q, row_d, col_q, col_d;
  logic last_row, last_col;
  assign pix = '{p1, p2, p3, p4, p5, p6, p7, p8, p9};
  assign last_col = col_q == 6'(IMG_W - 1);
  assign last_row = row_q == 6'(IMG_H - 1);
  assign busy = v1_q | v2_q | v3_q | (|row_q) | (|col_q);
  assign coef_hit = coef_wr && coef_addr <= 4'd9;
  assign coef_drop = coef_hit && (busy || win_valid);
  // kernel/shift update: writes land only while the engine is idle, otherwise flag the drop
  always_comb begin
    k_d = k_q;
    shift_d = (coef_hit && !coef_drop && coef_addr == 4'd9) ? coef_data[3:0] : shift_q;
    coef_err_d = coef_err_q | coef_drop;
    for (int i = 0; i < 9; i++)
      k_d[i] = (coef_hit && !coef_drop && coef_addr == 4'(i)) ? coef_data : k_q[i];
  end
  // S1 products and S2 row sums; pixels are unsigned so they get a zero sign bit
  always_comb begin
    for (int i = 0; i < 9; i++)
      prod_d[i] = PROD_W'($signed({1'b0, pix[i]})) * PROD_W'(k_q[i]);
    for (int r = 0; r < 3; r++)
      row_sum_d[r] = ROW_W'(prod_q[3*r]) + ROW_W'(prod_q[3*r+1]) + ROW_W'(prod_q[3*r+2]);
  end
  // S3 total, arithmetic shift, optional magnitude, clamp to the pixel range
  always_comb begin
    sum = SUM_W'(row_sum_q[0]) + SUM_W'(row_sum_q[1]) + SUM_W'(row_sum_q[2]);
    shifted = sum >>> shift_q;
`ifdef CONV3X3_ABS_EN
    mag = shifted[SUM_W-1] ? -shifted : shifted;
`else
    mag = shifted;
`endif
    pix_d = !v2_q ? pix_q : mag[SUM_W-1] ? '0 : (|mag[SUM_W-2:PIX_W]) ? '1 : mag[PIX_W-1:0];
  end
  // valid pipeline and output raster position, advanced once per emitted beat
  always_comb begin
    v1_d = win_valid;
    v2_d = v1_q;
    v3_d = v2_q;
    col_d = v3_q ? (last_col ? '0 : col_q + 6'd1) : col_q;
    row_d = (v3_q && last_col) ? (last_row ? '0 : row_q + 6'd1) : row_q;
  end
  // control state with synchronous active-low reset back to the identity kernel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) k_q[i] <= (i == 4) ? COEF_W'(1) : '0;
      shift_q <= '0;
      coef_err_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      pix_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      k_q <= k_d;
      shift_q <= shift_d;
      coef_err_q <= coef_err_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      pix_q <= pix_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end
  // datapath registers need no reset since the valid bits qualify them
  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    row_sum_q <= row_sum_d;
  end
  assign pix_out = pix_q;
  assign pix_valid = v3_q;
  assign out_row = row_q;
  assign out_col = col_q;
  assign frame_done = v3_q & last_row & last_col;
  assign coef_err = coef_err_q;
endmodule

// File: tb/tb_conv3x3_engine.sv
// tb_conv3x3_engine: random and directed stimulus checked every cycle against a behavioural convolution model
module tb_conv3x3_engine;
  localparam int IMG_W = 64;
  localparam int IMG_H = 64;
  localparam int NPIX = IMG_W * IMG_H;
`ifdef CONV3X3_ABS_EN
  localparam int SOBEL_NEG = 255;
`else
  localparam int SOBEL_NEG = 0;
`endif
  logic clk = 0, rst_n = 0, win_valid = 0, coef_wr = 0;
  logic [7:0] pin [9];
  logic [3:0] coef_addr = 0;
  logic [7:0] coef_data = 0;
  logic [7:0] pix_out;
  logic pix_valid, frame_done, busy, coef_err;
  logic [5:0] out_row, out_col;
  int total = 0, bad = 0;
  bit chk_en = 0;
  int beats = 0, fd_cnt = 0, fd_beat = 0;
  int m_k [9];
  int m_sh, m_pix, m_cnt;
  int m_r [2];
  bit [2:0] m_v;
  bit m_err;
  int w [9];

  conv3x3_engine dut (
    .clk(clk), .rst_n(rst_n), .win_valid(win_valid),
    .p1(pin[0]), .p2(pin[1]), .p3(pin[2]), .p4(pin[3]), .p5(pin[4]),
    .p6(pin[5]), .p7(pin[6]), .p8(pin[7]), .p9(pin[8]),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .pix_out(pix_out), .pix_valid(pix_valid), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done), .busy(busy), .coef_err(coef_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_busy();
    return (m_v != 0) || (m_cnt != 0);
  endfunction

  function automatic int conv_now();
    int s = 0;
    for (int i = 0; i < 9; i++) s += int'(pin[i]) * m_k[i];
    s = s >>> m_sh;
`ifdef CONV3X3_ABS_EN
    if (s < 0) s = -s;
`endif
    return s < 0 ? 0 : s > 255 ? 255 : s;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) m_k[i] <= (i == 4) ? 1 : 0;
      m_sh <= 0;
      m_err <= 0;
      m_v <= '0;
      m_pix <= 0;
      m_cnt <= 0;
    end else begin
      if (coef_wr && coef_addr <= 9) begin
        if (model_busy() || win_valid) m_err <= 1;
        else if (coef_addr == 9) m_sh <= int'(coef_data[3:0]);
        else m_k[coef_addr] <= int'($signed(coef_data));
      end
      m_v <= {m_v[1:0], win_valid};
      m_r[0] <= conv_now();
      m_r[1] <= m_r[0];
      if (m_v[1]) m_pix <= m_r[1];
      if (m_v[2]) m_cnt <= (m_cnt + 1) % NPIX;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pix_valid", pix_valid, m_v[2]);
      check("pix_out", pix_out, m_pix);
      check("out_row", out_row, m_cnt / IMG_W);
      check("out_col", out_col, m_cnt % IMG_W);
      check("frame_done", frame_done, m_v[2] && m_cnt == NPIX - 1);
      check("busy", busy, model_busy());
      check("coef_err", coef_err, m_err);
      if (pix_valid === 1'b1) begin
        beats++;
        if (frame_done === 1'b1) begin
          fd_cnt++;
          fd_beat = beats;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    win_valid = 0;
    coef_wr = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic wr(input int a, input int d);
    coef_wr = 1;
    coef_addr = 4'(a);
    coef_data = 8'(d);
    tick();
    coef_wr = 0;
  endtask

  task automatic send(input int px [9]);
    for (int i = 0; i < 9; i++) pin[i] = 8'(px[i]);
    win_valid = 1;
    tick();
    win_valid = 0;
  endtask

  task automatic expect_pix(input string name, input int exp);
    tick();
    check({name, "_early"}, pix_valid, 0);
    tick();
    check({name, "_valid"}, pix_valid, 1);
    check(name, pix_out, exp);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) pin[i] = 0;
    tick();
    chk_en = 1;
    tick();
    rst_n = 1;
    check("rst_pix_out", pix_out, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_row", out_row, 0);
    check("rst_col", out_col, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_coef_err", coef_err, 0);
    tick();
    // ignored address while idle, then identity kernel
    wr(12, 8'h55);
    check("addr12_err", coef_err, 0);
    for (int i = 0; i < 9; i++) w[i] = $urandom_range(0, 255);
    w[4] = 8'h5A;
    send(w);
    expect_pix("identity", 8'h5A);
    check("identity_row", out_row, 0);
    check("identity_col", out_col, 0);
    // box blur and saturation
    do_reset();
    for (int i = 0; i < 9; i++) wr(i, 1);
    wr(9, 3);
    for (int i = 0; i < 9; i++) w[i] = 100;
    send(w);
    expect_pix("box_blur", 112);
    do_reset();
    for (int i = 0; i < 9; i++) wr(i, 1);
    for (int i = 0; i < 9; i++) w[i] = 255;
    send(w);
    expect_pix("box_sat", 255);
    // Sobel-X with negative and positive gradients
    do_reset();
    w = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    for (int i = 0; i < 9; i++) wr(i, w[i]);
    w = '{200, 50, 0, 200, 50, 0, 200, 50, 0};
    send(w);
    expect_pix("sobel_neg", SOBEL_NEG);
    w = '{0, 77, 10, 0, 77, 10, 0, 77, 10};
    send(w);
    expect_pix("sobel_pos", 40);
    // full random frame with single-cycle gaps and a dropped write mid-stream
    do_reset();
    for (int i = 0; i < 9; i++) wr(i, $urandom_range(0, 255));
    wr(9, $urandom_range(0, 4));
    beats = 0;
    fd_cnt = 0;
    fd_beat = 0;
    for (int n = 0; n < NPIX; n++) begin
      for (int i = 0; i < 9; i++) pin[i] = 8'($urandom);
      win_valid = 1;
      if (n == 100) begin
        coef_wr = 1;
        coef_addr = 4'd4;
        coef_data = 8'd77;
      end
      tick();
      coef_wr = 0;
      win_valid = 0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    for (int i = 0; i < 4; i++) tick();
    check("stream_beats", beats, NPIX);
    check("stream_fd_cnt", fd_cnt, 1);
    check("stream_fd_beat", fd_beat, NPIX);
    check("stream_end_row", out_row, 0);
    check("stream_end_col", out_col, 0);
    check("stream_end_busy", busy, 0);
    check("busy_drop_err", coef_err, 1);
    wr(12, 8'h33);
    check("addr12_err_kept", coef_err, 1);
    for (int i = 0; i < 9; i++) w[i] = $urandom_range(0, 255);
    send(w);
    tick();
    tick();
    // write to k5 while busy with identity kernel in place
    do_reset();
    w = '{1, 2, 3, 4, 9, 6, 7, 8, 9};
    send(w);
    wr(4, 5);
    check("busy_wr_err", coef_err, 1);
    w[4] = 21;
    send(w);
    expect_pix("busy_wr_kernel", 21);
    check("busy_wr_err_sticky", coef_err, 1);
    // reset mid-frame with two windows in flight
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 9; i++) w[i] = $urandom_range(0, 255);
      send(w);
    end
    for (int i = 0; i < 9; i++) pin[i] = 8'($urandom);
    win_valid = 1;
    tick();
    for (int i = 0; i < 9; i++) pin[i] = 8'($urandom);
    tick();
    win_valid = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    check("midrst_row", out_row, 0);
    check("midrst_col", out_col, 0);
    check("midrst_err", coef_err, 0);
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_valid", pix_valid, 0);
      tick();
    end
    for (int i = 0; i < 9; i++) w[i] = $urandom_range(0, 255);
    w[4] = 8'h33;
    send(w);
    expect_pix("midrst_identity", 8'h33);
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv3x3_engine.md
Name: conv3x3_engine

Overview:
- Pipelined 3x3 convolution stage that consumes the nine-pixel window produced each cycle by the padded-frame window memory.
- Applies a runtime-programmable signed kernel, then shift, clamp and optional magnitude.
- Emits one 8-bit result per valid window, together with a write strobe and frame coordinates, to the result-memory write port.
- Tracks output position and flags end of frame.

Parameters:
- IMG_W, 64, output pixels per row (column counter wraps at IMG_W-1)
- IMG_H, 64, output rows per frame
- PIX_W, 8, unsigned pixel width
- COEF_W, 8, signed coefficient width

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- win_valid  input  1  p1..p9 hold a valid window this cycle
- p1..p9  input  PIX_W each  window, row-major (p1 top-left, p5 centre, p9 bottom-right), unsigned
- coef_wr  input  1  coefficient/shift write strobe
- coef_addr  input  4  0..8 select k1..k9; 9 selects shift; 10..15 ignored
- coef_data  input  COEF_W  signed coefficient; shift uses bits [3:0]
- pix_out  output  PIX_W  result pixel
- pix_valid  output  1  pix_out valid, drives result-memory write enable
- out_row  output  6  row of pix_out
- out_col  output  6  column of pix_out
- frame_done  output  1  one-cycle pulse with the last pixel of a frame
- busy  output  1  frame in progress or pipeline non-empty
- coef_err  output  1  sticky: a coefficient write was dropped

Behaviour:
- Reset (rst_n=0 at clk edge): pix_out=0, pix_valid=0, out_row=0, out_col=0, frame_done=0, coef_err=0, pipeline valids cleared.
- Reset kernel is identity: k5=1, all other k=0, shift=0. Reset mid-frame discards all in-flight data; nothing is emitted for it.
- Pipeline, fixed latency 3. win_valid at edge N gives pix_valid high after edge N+3. Bubbles in win_valid propagate unchanged; there is no backpressure.
- S1: nine products pi*ki. Each pi is zero-extended to PIX_W+1 signed bits, giving products of PIX_W+COEF_W+1 = 17 bits signed.
- S2: three row sums, 19 bits signed.
- S3: total sum, 21 bits signed, then arithmetic right shift by shift (0..15), then clamp to [0, 2^PIX_W-1] with negatives going to 0 (see optional feature). The result registers into pix_out.
- pix_out holds its last value when pix_valid=0.
- Counters: out_row/out_col show the coordinate of the current pix_valid beat, starting at (0,0).
  - After each valid beat: out_col increments; at IMG_W-1 it wraps to 0 and out_row increments.
  - The beat at (IMG_H-1, IMG_W-1) asserts frame_done in the same cycle; both counters then return to 0 for the next frame.
- busy=1 when either holds: any pipeline stage is valid, or the counters are not at (0,0).
- Coefficient writes:
  - Accepted only when busy=0 and win_valid=0. They take effect on the next cycle.
  - A coef_wr while busy=1 or win_valid=1 is dropped and sets coef_err. coef_err clears only on reset.
  - A write to addr 10..15 is ignored and does not set coef_err.
- Simultaneous coef_wr and win_valid: the write is dropped and coef_err is set; the window is processed with the old kernel.

Optional Feature:
- Macro CONV3X3_ABS_EN.
  - Defined: S3 takes the absolute value of the shifted sum before clamping, so negative results give their magnitude, clamped to 255. Intended for edge kernels.
  - Undefined: negative results clamp to 0.
- Latency is 3 in both builds.

Test Plan:
- Identity after reset; window p5=0x5A, other pixels arbitrary, one win_valid -> exactly 3 cycles later pix_valid=1, pix_out=0x5A, out_row=0, out_col=0.
- Box blur: all k=1, shift=3, all pixels=100 -> pix_out=112; all pixels=255 with shift=0 -> pix_out=255 (saturation).
- Sobel-X kernel [-1 0 1; -2 0 2; -1 0 1], left column=200, right column=0:
  - Sum is -800.
  - Without CONV3X3_ABS_EN -> pix_out=0.
  - With CONV3X3_ABS_EN -> pix_out=255.
  - Left column 0, right column 10 -> pix_out=40 in both builds.
- Stream 4096 windows with random single-cycle win_valid gaps:
  - exactly 4096 pix_valid beats;
  - out_col wraps 63->0 with out_row incrementing;
  - frame_done high only on beat 4096 at (63,63);
  - counters read (0,0) afterwards and busy falls 1 cycle later.
- coef_wr to k5 while busy=1 -> kernel unchanged, coef_err=1 and stays 1. A write to addr 12 when idle -> no effect, coef_err unchanged.
- rst_n low for 1 cycle mid-frame with 2 windows in flight -> no pix_valid for those windows, counters=(0,0), kernel back to identity, coef_err=0.
